// File: rtl/dmem_if.sv
// dmem_if: request/response channels between the
// memory-access stage and the data-memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_funct;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_funct,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM serving LB/LH/LW/LBU/LHU
// and SB/SH/SW with fixed latency, one outstanding.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } acc_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_t state;
  state_t state_d;
  logic [3:0] cnt;
  logic [3:0] cnt_d;

  logic accept;
  logic enter_resp;
  logic ready_o;
  logic valid_o;

  logic [DEPTH_LOG2-1:0] idx;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [31:0] word;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  logic is_b;
  logic is_h;
  logic is_w;
  logic is_u;
  logic legal;
  logic err;
  logic b_ok;
  logic h_ok;
  logic w_ok;
  acc_t acc;

  logic [31:0] pend_rdata;
  logic        pend_err;
  logic [31:0] rdata_q;
  logic        err_q;

  logic unused;

  assign f3     = bus.req_funct[2:0];
  assign off    = bus.req_addr[1:0];
  assign idx    = bus.req_addr[DEPTH_LOG2+1:2];
  assign word   = mem[idx];
  assign unused = ^{bus.req_funct[9:3],
                    bus.req_addr[31:DEPTH_LOG2+2]};

  // lane select of the addressed word
  always_comb begin
    sel_b = word[{off, 3'b000} +: 8];
    sel_h = off[1] ? word[31:16] : word[15:0];
  end

  // funct3 -> access width, signedness, legality
  always_comb begin
    is_b  = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    is_u  = 1'b0;
    legal = 1'b0;
    case (f3)
      3'b000: begin
        is_b  = 1'b1;
        legal = 1'b1;
      end
      3'b001: begin
        is_h  = 1'b1;
        legal = 1'b1;
      end
      3'b010: begin
        is_w  = 1'b1;
        legal = 1'b1;
      end
      3'b100: begin
        is_b  = 1'b1;
        is_u  = 1'b1;
        legal = !bus.req_we;
      end
      3'b101: begin
        is_h  = 1'b1;
        is_u  = 1'b1;
        legal = !bus.req_we;
      end
      default: ;
    endcase
  end

  assign err  = !legal
              || (is_h && off[0])
              || (is_w && (off != 2'b00));
  assign b_ok = is_b && !err;
  assign h_ok = is_h && !err;
  assign w_ok = is_w && !err;

  // byte enables, store lanes and extended load data
  always_comb begin
    acc = '0;
    unique case (1'b1)
      b_ok: begin
        acc.be    = 4'b0001 << off;
        acc.wdata = {4{bus.req_wdata[7:0]}};
        acc.rdata = is_u ? {24'b0, sel_b}
                         : {{24{sel_b[7]}}, sel_b};
      end
      h_ok: begin
        acc.be    = off[1] ? 4'b1100 : 4'b0011;
        acc.wdata = {2{bus.req_wdata[15:0]}};
        acc.rdata = is_u ? {16'b0, sel_h}
                         : {{16{sel_h[15]}}, sel_h};
      end
      w_ok: begin
        acc.be    = 4'b1111;
        acc.wdata = bus.req_wdata;
        acc.rdata = word;
      end
      default: ;
    endcase
    if (bus.req_we) begin
      acc.rdata = '0;
    end else begin
      acc.be = '0;
    end
  end

  // state and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // next state: accept, count down, wait for consumer
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs and internal strobes
  always_comb begin
    ready_o    = (state == IDLE);
    valid_o    = (state == RESP);
    accept     = ready_o && bus.req_valid && rst_n;
    enter_resp = (state != RESP) && (state_d == RESP);
  end

  assign bus.req_ready  = ready_o;
  assign bus.resp_valid = valid_o;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // capture at acceptance, publish on entry to RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rdata <= '0;
      pend_err   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        pend_rdata <= acc.rdata;
        pend_err   <= err;
      end
      if (enter_resp) begin
        if (state == IDLE) begin
          rdata_q <= acc.rdata;
          err_q   <= err;
        end else begin
          rdata_q <= pend_rdata;
          err_q   <= pend_err;
        end
      end
    end
  end

  // store commit with byte enables at acceptance
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc.be[i]) begin
          mem[idx][8*i +: 8] <= acc.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the memory-access stage's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Word-organised RAM with byte/halfword/word access selected by funct3 and sign/zero extension on loads.
- Configurable access latency, one outstanding request, and a misalignment error flag.
- Gives the memory-access stage a real "responds" event to drive its ready-go in place of a constant.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; byte address bits [DEPTH_LOG2+1:2] index the array, upper bits ignored.
- LATENCY, 2, cycles from request acceptance edge to resp_valid high; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct  input  10  {funct7, funct3}; only [2:0] is used.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned access or illegal funct3.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0. RAM contents are not reset.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, the request is accepted at that edge and the FSM moves to WAIT; the counter loads LATENCY-1.
  - WAIT: req_ready = 0. The counter decrements each cycle; at 0 the FSM moves to RESP. With LATENCY = 1, WAIT is skipped and the FSM goes straight to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are held stable. On resp_ready, the FSM returns to IDLE.
- req_ready is never high in RESP: one outstanding request, no back-to-back overlap. Minimum spacing between acceptances is LATENCY+1 cycles.
- Acceptance edge actions:
  - Store: the write is committed to RAM with byte enables.
  - Load: the addressed word is captured. Because the write commits at acceptance, a load accepted after a store sees the stored data.
- funct3 decode:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Byte/half selected by addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Store: 000 SB, 001 SH, 010 SW.
- Error cases (resp_err = 1, no RAM write, resp_rdata = 0):
  - Any other funct3, including load 011/110/111 and store 011..111.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
- Stores always return resp_rdata = 0.
- resp_rdata and resp_err are registered, update only when the FSM enters RESP, and hold until the next entry into RESP.
- req_* inputs are ignored outside IDLE; the requester may change or drop them freely.
- Reset mid-operation: the pending response is discarded and the FSM returns to IDLE. A store whose acceptance edge has already occurred remains written.
- Address bits above DEPTH_LOG2+1 alias; this is not an error.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10, LATENCY = 2 → each resp_valid rises exactly 2 cycles after acceptance; load returns resp_rdata = 0xDEADBEEF, resp_err = 0.
- Starting from 0xDEADBEEF at 0x10, SB 0x13 data 0x80, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF80AD; LHU 0x10 → 0x0000BEEF.
- SH addr 0x21 and LW addr 0x22 → resp_err = 1, resp_rdata = 0; a subsequent LW 0x20 shows the word unchanged from its prior value.
- resp_ready held low for 5 cycles in RESP → resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0. The cycle after resp_ready = 1, req_ready = 1 and resp_valid = 0.
- Assert rst_n low while in WAIT during a load → resp_valid = 0 and req_ready = 1 immediately (asynchronous), with no response delivered after release. A store accepted before the reset is still readable afterwards.
- LATENCY = 1, repeated requests with resp_ready tied high → acceptances every 2 cycles; resp_valid 1 cycle after each acceptance.
